int_req_ctrl: RTL and testbench

- Interrupt request controller directly upstream of the RISC-V core's `int_sig` input.
- Consumes debounced buttons and raw slide switches, edge-detects them, and latches per-source pending bits.
- Presents one prioritised, level-held request (`int_sig` plus `int_id`) to the core until the core acknowledges it.
- Replaces the plain OR of button and switch levels, so the core sees each event exactly once.

---
 rtl/int_req_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_int_req_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: edge-detects buttons/switches, latches pending bits,
// presents one prioritised held request to the core. Optional INT_REQ_SYNC_EN adds input synchronisers.
module int_req_ctrl #(
    parameter int NBTN = 4,
    parameter int NSW  = 3,
    parameter int GAP  = 2,
    parameter int IDW  = 3
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [NBTN-1:0]      btn_in,
    input  logic [NSW-1:0]       switch_in,
    input  logic [NBTN+NSW-1:0]  int_mask,
    input  logic                 int_ack,
    output logic                 int_sig,
    output logic [IDW-1:0]       int_id,
    output logic [NBTN+NSW-1:0]  int_pending
);

    localparam int NS = NBTN + NSW;
    localparam int CW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sig;
    logic            w_sig_nxt;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  w_id_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_ack_clr;

    logic [NBTN-1:0] w_btn;
    logic [NSW-1:0]  w_sw;
    logic [NBTN-1:0] r_btn_prev;
    logic [NSW-1:0]  r_sw_prev;
    logic            r_arm;
    logic [NS-1:0]   w_ev;
    logic [NS-1:0]   w_clr;
    logic [NS-1:0]   r_pend;
    logic [NS-1:0]   w_req;
    logic [IDW-1:0]  w_top;

`ifdef INT_REQ_SYNC_EN
    logic [NBTN-1:0] r_btn_s1;
    logic [NBTN-1:0] r_btn_s2;
    logic [NSW-1:0]  r_sw_s1;
    logic [NSW-1:0]  r_sw_s2;
    logic [1:0]      r_arm_cnt;

    // Arm only once the synchroniser pipeline holds real input samples
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_arm_cnt <= '0;
            r_arm     <= 1'b0;
        end else begin
            r_btn_s1  <= btn_in;
            r_btn_s2  <= r_btn_s1;
            r_sw_s1   <= switch_in;
            r_sw_s2   <= r_sw_s1;
            if (r_arm_cnt != 2'd3)
                r_arm_cnt <= r_arm_cnt + 2'd1;
            if (r_arm_cnt == 2'd2)
                r_arm <= 1'b1;
        end
    end

    assign w_btn = r_btn_s2;
    assign w_sw  = r_sw_s2;
`else
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            r_arm <= 1'b0;
        else
            r_arm <= 1'b1;
    end

    assign w_btn = btn_in;
    assign w_sw  = switch_in;
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_btn_prev <= '0;
            r_sw_prev  <= '0;
        end else begin
            r_btn_prev <= w_btn;
            r_sw_prev  <= w_sw;
        end
    end

    assign w_ev = {w_sw ^ r_sw_prev, w_btn & ~r_btn_prev} & {NS{r_arm}};

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NS; i++)
            w_clr[i] = w_ack_clr && (r_id == IDW'(i));
    end

    // A new event on the acknowledged source wins over the clear
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            r_pend <= '0;
        else
            r_pend <= (r_pend & ~w_clr) | w_ev;
    end

    assign w_req = r_pend & int_mask;

    always_comb begin
        w_top = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (w_req[i])
                w_top = IDW'(i);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sig   <= 1'b0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_id    <= w_id_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Last gap cycle re-evaluates requests so the low time is exactly GAP
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_id_nxt    = r_id;
        w_cnt_nxt   = r_cnt;
        w_ack_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_sig_nxt = 1'b0;
                if (|w_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_sig_nxt   = 1'b1;
                    w_id_nxt    = w_top;
                end
            end
            ST_ASSERT: begin
                w_sig_nxt = 1'b1;
                if (int_ack) begin
                    w_ack_clr   = 1'b1;
                    w_sig_nxt   = 1'b0;
                    w_cnt_nxt   = CW'(GAP);
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_sig_nxt = 1'b0;
                if (r_cnt <= CW'(1)) begin
                    w_cnt_nxt = '0;
                    if (|w_req) begin
                        w_state_nxt = ST_ASSERT;
                        w_sig_nxt   = 1'b1;
                        w_id_nxt    = w_top;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sig_nxt   = 1'b0;
            end
        endcase
    end

    assign int_sig     = r_sig;
    assign int_id      = r_id;
    assign int_pending = r_pend;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Directed self-checking bench for int_req_ctrl (default build, GAP=2).
module tb_int_req_ctrl;

    logic       CLK;
    logic       rst;
    logic [3:0] btn_in;
    logic [2:0] switch_in;
    logic [6:0] int_mask;
    logic       int_ack;
    logic       int_sig;
    logic [2:0] int_id;
    logic [6:0] int_pending;

    int n_chk;
    int n_pass;
    logic any_sig;

    int_req_ctrl #(
        .NBTN(4),
        .NSW (3),
        .GAP (2),
        .IDW (3)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .btn_in     (btn_in),
        .switch_in  (switch_in),
        .int_mask   (int_mask),
        .int_ack    (int_ack),
        .int_sig    (int_sig),
        .int_id     (int_id),
        .int_pending(int_pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        btn_in    = 4'h0;
        switch_in = 3'b101;
        int_mask  = 7'h00;
        int_ack   = 1'b0;
        repeat (3) tick();
        chk("rst_sig", {31'd0, int_sig}, 32'd0);
        chk("rst_id", {29'd0, int_id}, 32'd0);
        chk("rst_pend", {25'd0, int_pending}, 32'd0);

        rst     = 1'b0;
        any_sig = 1'b0;
        int_mask = 7'h7F;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_sig = any_sig | int_sig;
        end
        chk("arm_sig", {31'd0, any_sig}, 32'd0);
        chk("arm_pend", {25'd0, int_pending}, 32'd0);

        btn_in[2] = 1'b1;
        tick();
        chk("b2_pend", {25'd0, int_pending}, 32'h04);
        chk("b2_sig_e0", {31'd0, int_sig}, 32'd0);
        btn_in[2] = 1'b0;
        tick();
        chk("b2_sig", {31'd0, int_sig}, 32'd1);
        chk("b2_id", {29'd0, int_id}, 32'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("b2_ack_sig", {31'd0, int_sig}, 32'd0);
        chk("b2_ack_pend", {25'd0, int_pending}, 32'd0);
        tick();
        chk("b2_gap1", {31'd0, int_sig}, 32'd0);
        tick();
        chk("b2_gap2", {31'd0, int_sig}, 32'd0);

        btn_in[3]    = 1'b1;
        switch_in[0] = 1'b0;
        tick();
        chk("dual_pend", {25'd0, int_pending}, 32'h18);
        btn_in[3] = 1'b0;
        tick();
        chk("dual_sig", {31'd0, int_sig}, 32'd1);
        chk("dual_id3", {29'd0, int_id}, 32'd3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("dual_ack_sig", {31'd0, int_sig}, 32'd0);
        chk("dual_ack_pend", {25'd0, int_pending}, 32'h10);
        tick();
        chk("dual_gap", {31'd0, int_sig}, 32'd0);
        tick();
        chk("dual_resig", {31'd0, int_sig}, 32'd1);
        chk("dual_id4", {29'd0, int_id}, 32'd4);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("dual_clr", {25'd0, int_pending}, 32'h00);
        repeat (3) tick();

        int_mask  = 7'h7E;
        btn_in[0] = 1'b1;
        tick();
        chk("mask_pend", {25'd0, int_pending}, 32'h01);
        btn_in[0] = 1'b0;
        tick();
        chk("mask_sig1", {31'd0, int_sig}, 32'd0);
        tick();
        chk("mask_sig2", {31'd0, int_sig}, 32'd0);
        int_mask = 7'h7F;
        tick();
        chk("unmask_sig", {31'd0, int_sig}, 32'd1);
        chk("unmask_id", {29'd0, int_id}, 32'd0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        repeat (3) tick();
        chk("unmask_idle", {31'd0, int_sig}, 32'd0);

        switch_in[1] = 1'b1;
        tick();
        chk("s1_pend", {25'd0, int_pending}, 32'h20);
        tick();
        chk("s1_sig", {31'd0, int_sig}, 32'd1);
        chk("s1_id", {29'd0, int_id}, 32'd5);
        int_ack      = 1'b1;
        switch_in[1] = 1'b0;
        tick();
        chk("race_pend", {25'd0, int_pending}, 32'h20);
        chk("race_sig", {31'd0, int_sig}, 32'd0);
        tick();
        int_ack = 1'b0;
        chk("stray_pend", {25'd0, int_pending}, 32'h20);
        chk("stray_sig", {31'd0, int_sig}, 32'd0);
        tick();
        chk("rereq_sig", {31'd0, int_sig}, 32'd1);
        chk("rereq_id", {29'd0, int_id}, 32'd5);

        rst = 1'b1;
        #2;
        chk("arst_sig", {31'd0, int_sig}, 32'd0);
        chk("arst_pend", {25'd0, int_pending}, 32'h00);
        chk("arst_id", {29'd0, int_id}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("rearm_pend", {25'd0, int_pending}, 32'h00);
        chk("rearm_sig", {31'd0, int_sig}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
